// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: byte-lane masked synchronous write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately never reset; only enabled lanes are updated.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Sequential data-memory slave with fixed wait states and misaligned/out-of-range flagging.
// Optional byte-lane store enables are compiled in with `define DMEM_BYTE_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    dmem_state_t state;
    logic [3:0]  count;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic [3:0]  req_mask;
    logic        accept;
    logic        do_access;
    logic        acc_write;
    logic        acc_err;
    logic        mem_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic [31:0] mem_rdata;

`ifdef DMEM_BYTE_EN
    assign req_mask = req_be;
`else
    assign req_mask = 4'hF;
`endif

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With no wait states the access happens at the acceptance edge, so it uses the live request.
    assign acc_write = ZERO_WAIT ? req_write : lat_write;
    assign acc_addr  = ZERO_WAIT ? req_addr  : lat_addr;
    assign acc_wdata = ZERO_WAIT ? req_wdata : lat_wdata;
    assign acc_be    = ZERO_WAIT ? req_mask  : lat_be;
    assign do_access = ZERO_WAIT ? accept : ((state == WAIT) && (count == 4'd0));

    // Full 30-bit word index compare, so high address bits never alias onto real words.
    assign acc_err = (acc_addr[ADDR_LSB-1:0] != '0) ||
                     ({{ADDR_LSB{1'b0}}, acc_addr[31:ADDR_LSB]} >= 32'(DEPTH));
    assign mem_we  = do_access && acc_write && !acc_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (acc_be),
        .addr  (acc_addr[ADDR_LSB +: AW]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    // Request latch, wait counter and registered response in one state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_mask;
                        if (ZERO_WAIT) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= acc_err;
                            rsp_rdata <= (acc_write || acc_err) ? 32'd0 : mem_rdata;
                        end else begin
                            count <= 4'(WAIT_CYCLES - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_write || acc_err) ? 32'd0 : mem_rdata;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a 2-wait-state and a 0-wait-state responder against an array memory model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WC_A  = 2;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic        post_valid;
        logic        post_ready;
        logic [31:0] post_rdata;
        bit          tmo;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'hF;
    logic        rsp_ready = 1'b0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;
    logic        a_req_valid, z_req_valid;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mdl [2][DEPTH];

    always #5 clk = ~clk;

    assign a_req_valid = req_valid && !sel;
    assign z_req_valid = req_valid && sel;
    assign req_ready   = sel ? z_req_ready : a_req_ready;
    assign rsp_valid   = sel ? z_rsp_valid : a_rsp_valid;
    assign rsp_err     = sel ? z_rsp_err   : a_rsp_err;
    assign rsp_rdata   = sel ? z_rsp_rdata : a_rsp_rdata;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC_A)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DMEM_BYTE_EN
        .req_be    (req_be),
`endif
        .rsp_valid (a_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (a_rsp_rdata),
        .rsp_err   (a_rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk       (clk),
        .reset     (reset),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DMEM_BYTE_EN
        .req_be    (req_be),
`endif
        .rsp_valid (z_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err)
    );

    // Reference: a memory access either faults or reads/updates one word of a plain array.
    function automatic void model_apply(input bit s, input bit wr, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be,
                                        output logic exp_err, output logic [31:0] exp_rdata);
        int unsigned w;
        logic [3:0]  eff;
`ifdef DMEM_BYTE_EN
        eff = be;
`else
        eff = 4'hF | be;
`endif
        w = addr / 4;
        exp_err = ((addr % 4) != 0) || (w >= DEPTH);
        exp_rdata = 32'd0;
        if (!exp_err) begin
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (eff[i]) mdl[s][w][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                exp_rdata = mdl[s][w];
            end
        end
    endfunction

    // Drives one request from a negedge, returns what was seen when the response appeared.
    task automatic issue(input bit s, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit rdy, output obs_t o);
        int cnt;
        sel = s; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        rsp_ready = rdy; req_valid = 1'b1;
        o.tmo = 1'b0;
        #1;
        cnt = 0;
        while (!req_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!req_ready) o.tmo = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        o.lat = 1;
        while (!rsp_valid && o.lat < 50) begin
            @(negedge clk);
            o.lat++;
        end
        if (!rsp_valid) o.tmo = 1'b1;
        o.rdata = rsp_rdata;
        o.err   = rsp_err;
        o.post_valid = rsp_valid;
        o.post_ready = req_ready;
        o.post_rdata = rsp_rdata;
        if (rdy) begin
            @(negedge clk);
            o.post_valid = rsp_valid;
            o.post_ready = req_ready;
            o.post_rdata = rsp_rdata;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (a_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req_ready_a got %b want 0", a_req_ready); end
        vectors++; if (a_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid_a got %b want 0", a_rsp_valid); end
        vectors++; if (a_rsp_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rsp_rdata_a got %h want 0", a_rsp_rdata); end
        vectors++; if (a_rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_err_a got %b want 0", a_rsp_err); end
        vectors++; if (z_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req_ready_z got %b want 0", z_req_ready); end
        vectors++; if (z_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid_z got %b want 0", z_rsp_valid); end
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (a_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_ready_a got %b want 1", a_req_ready); end
        vectors++; if (z_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_ready_z got %b want 1", z_req_ready); end
    endtask

    task automatic test_store_load();
        obs_t o; logic ee; logic [31:0] er;
        model_apply(0, 1, 32'hFC4, 32'd1024, 4'hF, ee, er);
        issue(0, 1, 32'hFC4, 32'd1024, 4'hF, 1, o);
        vectors++; if (o.tmo) begin miscompares++; $display("[TB] FAIL store_timeout got 1 want 0"); end
        vectors++; if (o.lat != WC_A + 1) begin miscompares++; $display("[TB] FAIL store_latency got %0d want %0d", o.lat, WC_A + 1); end
        vectors++; if (o.err !== ee) begin miscompares++; $display("[TB] FAIL store_err got %b want %b", o.err, ee); end
        vectors++; if (o.rdata !== er) begin miscompares++; $display("[TB] FAIL store_rdata got %h want %h", o.rdata, er); end
        vectors++; if (o.post_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_handshake_valid got %b want 0", o.post_valid); end
        vectors++; if (o.post_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL store_back_to_idle got %b want 1", o.post_ready); end
        model_apply(0, 0, 32'hFC4, 32'd0, 4'hF, ee, er);
        issue(0, 0, 32'hFC4, 32'd0, 4'hF, 1, o);
        vectors++; if (o.lat != WC_A + 1) begin miscompares++; $display("[TB] FAIL load_latency got %0d want %0d", o.lat, WC_A + 1); end
        vectors++; if (o.rdata !== er) begin miscompares++; $display("[TB] FAIL load_rdata got %h want %h", o.rdata, er); end
        vectors++; if (o.err !== ee) begin miscompares++; $display("[TB] FAIL load_err got %b want %b", o.err, ee); end
    endtask

    task automatic test_errors();
        obs_t o; logic ee; logic [31:0] er;
        logic [31:0] addrs [5] = '{32'h0, 32'h102, 32'h1000, 32'h4000_0000, 32'h0};
        bit          wrs   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            d = (i == 0) ? 32'h5A5A_0001 : $urandom;
            model_apply(0, wrs[i], addrs[i], d, 4'hF, ee, er);
            issue(0, wrs[i], addrs[i], d, 4'hF, 1, o);
            vectors++; if (o.err !== ee) begin miscompares++; $display("[TB] FAIL err_flag[%0d] addr %h got %b want %b", i, addrs[i], o.err, ee); end
            vectors++; if (o.rdata !== er) begin miscompares++; $display("[TB] FAIL err_rdata[%0d] addr %h got %h want %h", i, addrs[i], o.rdata, er); end
            vectors++; if (o.post_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL err_clear[%0d] got %b want 0", i, o.post_valid); end
        end
        vectors++; if (a_rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_after_handshake got %b want 0", a_rsp_err); end
    endtask

    task automatic test_backpressure();
        obs_t o; logic ee; logic [31:0] er;
        model_apply(0, 0, 32'hFC4, 32'd0, 4'hF, ee, er);
        issue(0, 0, 32'hFC4, 32'd0, 4'hF, 0, o);
        vectors++; if (o.rdata !== er) begin miscompares++; $display("[TB] FAIL bp_rdata got %h want %h", o.rdata, er); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid[%0d] got %b want 1", i, rsp_valid); end
            vectors++; if (rsp_rdata !== er) begin miscompares++; $display("[TB] FAIL bp_hold_rdata[%0d] got %h want %h", i, rsp_rdata, er); end
            vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_err[%0d] got %b want 0", i, rsp_err); end
            vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_req_ready[%0d] got %b want 0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release_valid got %b want 0", rsp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release_ready got %b want 1", req_ready); end
        vectors++; if (rsp_rdata !== er) begin miscompares++; $display("[TB] FAIL bp_rdata_kept got %h want %h", rsp_rdata, er); end
    endtask

    task automatic test_reset_midop();
        obs_t o; logic ee; logic [31:0] er;
        model_apply(0, 1, 32'h40, 32'h1111_1111, 4'hF, ee, er);
        issue(0, 1, 32'h40, 32'h1111_1111, 4'hF, 1, o);
        model_apply(0, 0, 32'h40, 32'd0, 4'hF, ee, er);
        issue(0, 0, 32'h40, 32'd0, 4'hF, 1, o);
        sel = 1'b0; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        vectors++; if (a_rsp_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL midreset_rdata got %h want 0", a_rsp_rdata); end
        vectors++; if (a_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_valid got %b want 0", a_rsp_valid); end
        vectors++; if (a_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_ready got %b want 0", a_req_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (a_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_no_late_rsp got %b want 0", a_rsp_valid); end
        issue(0, 0, 32'h40, 32'd0, 4'hF, 1, o);
        vectors++; if (o.rdata !== er) begin miscompares++; $display("[TB] FAIL midreset_mem_kept got %h want %h", o.rdata, er); end
    endtask

    task automatic test_zero_wait();
        obs_t o; logic ee; logic [31:0] er; logic [31:0] d;
        d = $urandom;
        model_apply(1, 1, 32'h8, d, 4'hF, ee, er);
        issue(1, 1, 32'h8, d, 4'hF, 1, o);
        vectors++; if (o.lat != 1) begin miscompares++; $display("[TB] FAIL zw_store_latency got %0d want 1", o.lat); end
        vectors++; if (o.post_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL zw_store_idle got %b want 1", o.post_ready); end
        model_apply(1, 0, 32'h8, 32'd0, 4'hF, ee, er);
        issue(1, 0, 32'h8, 32'd0, 4'hF, 1, o);
        vectors++; if (o.lat != 1) begin miscompares++; $display("[TB] FAIL zw_load_latency got %0d want 1", o.lat); end
        vectors++; if (o.rdata !== er) begin miscompares++; $display("[TB] FAIL zw_load_rdata got %h want %h", o.rdata, er); end
        model_apply(1, 0, 32'h1001, 32'd0, 4'hF, ee, er);
        issue(1, 0, 32'h1001, 32'd0, 4'hF, 1, o);
        vectors++; if (o.err !== ee) begin miscompares++; $display("[TB] FAIL zw_err got %b want %b", o.err, ee); end
    endtask

`ifdef DMEM_BYTE_EN
    task automatic test_byte_enable();
        obs_t o; logic ee; logic [31:0] er;
        model_apply(0, 1, 32'h10, 32'hAABB_CCDD, 4'hF, ee, er);
        issue(0, 1, 32'h10, 32'hAABB_CCDD, 4'hF, 1, o);
        model_apply(0, 1, 32'h10, 32'h1122_3344, 4'b0101, ee, er);
        issue(0, 1, 32'h10, 32'h1122_3344, 4'b0101, 1, o);
        model_apply(0, 1, 32'h10, 32'hFFFF_FFFF, 4'b0000, ee, er);
        issue(0, 1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1, o);
        vectors++; if (o.err !== 1'b0) begin miscompares++; $display("[TB] FAIL be_zero_err got %b want 0", o.err); end
        model_apply(0, 0, 32'h10, 32'd0, 4'b0000, ee, er);
        issue(0, 0, 32'h10, 32'd0, 4'b0000, 1, o);
        vectors++; if (o.rdata !== er) begin miscompares++; $display("[TB] FAIL be_merge got %h want %h", o.rdata, er); end
    endtask
`endif

    task automatic test_random();
        obs_t o; logic ee; logic [31:0] er;
        for (int s = 0; s < 2; s++) begin
            for (int idx = 0; idx < 12; idx++) begin
                int unsigned w; logic [31:0] d;
                w = (idx < 8) ? idx : DEPTH - 12 + idx;
                d = $urandom;
                model_apply(s[0], 1, w * 4, d, 4'hF, ee, er);
                issue(s[0], 1, w * 4, d, 4'hF, 1, o);
                vectors++; if (o.err !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_init_err word %0d got %b want 0", w, o.err); end
            end
        end
        for (int n = 0; n < 80; n++) begin
            bit s, wr; int unsigned idx, w; logic [31:0] addr, d; logic [3:0] be;
            s = 1'($urandom); wr = 1'($urandom); d = $urandom; be = 4'($urandom);
            idx = $urandom % 12;
            w = (idx < 8) ? idx : DEPTH - 12 + idx;
            case ($urandom % 4)
                0, 1: addr = w * 4;
                2:    addr = w * 4 + 1 + ($urandom % 3);
                default: begin
                    addr = $urandom | 32'h0000_1000;
                    addr = addr & 32'hFFFF_FFFC;
                end
            endcase
            model_apply(s, wr, addr, d, be, ee, er);
            issue(s, wr, addr, d, be, 1, o);
            vectors++; if (o.tmo || o.lat != (s ? 1 : WC_A + 1)) begin miscompares++; $display("[TB] FAIL rnd_latency[%0d] got %0d want %0d", n, o.lat, s ? 1 : WC_A + 1); end
            vectors++; if (o.err !== ee) begin miscompares++; $display("[TB] FAIL rnd_err[%0d] addr %h got %b want %b", n, addr, o.err, ee); end
            vectors++; if (o.rdata !== er) begin miscompares++; $display("[TB] FAIL rnd_rdata[%0d] addr %h got %h want %h", n, addr, o.rdata, er); end
            vectors++; if (o.post_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_handshake[%0d] got %b want 0", n, o.post_valid); end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_midop();
        test_zero_wait();
`ifdef DMEM_BYTE_EN
        test_byte_enable();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
